// File: rtl/ap_isa_pkg.sv
// Shared types and constants for the AP accelerator instruction dispatcher.
// Instruction word = {class[1:0], payload[31:0]}.
package ap_isa_pkg;

    localparam int ISA_W     = 34;
    localparam int PAYLOAD_W = 32;

    localparam logic [1:0] CLS_BARRIER = 2'b00;
    localparam logic [1:0] CLS_DMA     = 2'b01;
    localparam logic [1:0] CLS_COMPUTE = 2'b10;
    localparam logic [1:0] CLS_HALT    = 2'b11;

    // Execution units tracked for outstanding commands
    localparam int N_UNITS  = 2;
    localparam int UNIT_DMA = 0;
    localparam int UNIT_CMP = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_ISSUE,
        ST_DRAIN_B,
        ST_DRAIN_H,
        ST_HALTED
    } state_t;

    function automatic logic [1:0] isa_class(input logic [ISA_W-1:0] instr);
        return instr[ISA_W-1 -: 2];
    endfunction

endpackage

// File: rtl/ap_outstanding_ctr.sv
// Counts commands issued to one unit but not yet completed.
// A done pulse with nothing outstanding is flagged and leaves the count at zero.
module ap_outstanding_ctr #(
    parameter int MAX_OUT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero,
    output logic underflow
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [OUT_W-1:0] count_reg, count_next;
    logic             dec_ok;

    assign zero      = (count_reg == '0);
    assign full      = (count_reg >= OUT_W'(MAX_OUT));
    assign underflow = dec && zero;
    assign dec_ok    = dec && !zero;

    // Issue and completion on the same edge cancel out
    always_comb begin
        count_next = count_reg;
        if (inc && !dec_ok) begin
            count_next = count_reg + OUT_W'(1);
        end else if (dec_ok && !inc) begin
            count_next = count_reg - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/ap_isa_dispatcher.sv
// AP accelerator instruction scheduler: pops ISA words, issues DMA/compute commands,
// tracks outstanding work per unit and enforces BARRIER/HALT ordering.
module ap_isa_dispatcher
    import ap_isa_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 isa_fifo_empty,
    input  logic [ISA_W-1:0]     isa_fifo_dout,
    output logic                 isa_fifo_rd_en,
    output logic                 dma_cmd_valid,
    input  logic                 dma_cmd_ready,
    output logic [PAYLOAD_W-1:0] dma_cmd_data,
    input  logic                 dma_done,
    output logic                 cmp_cmd_valid,
    input  logic                 cmp_cmd_ready,
    output logic [PAYLOAD_W-1:0] cmp_cmd_data,
    input  logic                 cmp_done,
    output logic                 busy,
    output logic                 halted,
    output logic                 err,
    output logic [CNT_W-1:0]     instr_count
);

    state_t             state_reg, state_next;
    logic [ISA_W-1:0]   ir_reg, ir_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               err_reg, err_next;
    logic               retire;
    logic               clear_run;
    logic [1:0]         ir_class;

    logic [N_UNITS-1:0] unit_inc;
    logic [N_UNITS-1:0] unit_dec;
    logic [N_UNITS-1:0] unit_full;
    logic [N_UNITS-1:0] unit_zero;
    logic [N_UNITS-1:0] unit_underflow;

    assign unit_inc[UNIT_DMA] = dma_cmd_valid && dma_cmd_ready;
    assign unit_inc[UNIT_CMP] = cmp_cmd_valid && cmp_cmd_ready;
    assign unit_dec[UNIT_DMA] = dma_done;
    assign unit_dec[UNIT_CMP] = cmp_done;

    generate
        for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_unit
            ap_outstanding_ctr #(
                .MAX_OUT (MAX_OUT)
            ) u_ctr (
                .clk       (clk),
                .rst       (rst),
                .inc       (unit_inc[gi]),
                .dec       (unit_dec[gi]),
                .full      (unit_full[gi]),
                .zero      (unit_zero[gi]),
                .underflow (unit_underflow[gi])
            );
        end
    endgenerate

    assign ir_class = isa_class(ir_reg);

    always_comb begin
        state_next     = state_reg;
        isa_fifo_rd_en = 1'b0;
        dma_cmd_valid  = 1'b0;
        cmp_cmd_valid  = 1'b0;
        retire         = 1'b0;
        clear_run      = 1'b0;

        case (state_reg)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    clear_run  = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                isa_fifo_rd_en = !isa_fifo_empty;
                if (!isa_fifo_empty) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Room only grows while stalled, so valid never drops before ready
                case (ir_class)
                    CLS_DMA: begin
                        dma_cmd_valid = !unit_full[UNIT_DMA];
                        if (dma_cmd_valid && dma_cmd_ready) begin
                            retire     = 1'b1;
                            state_next = ST_FETCH;
                        end
                    end
                    CLS_COMPUTE: begin
                        cmp_cmd_valid = !unit_full[UNIT_CMP];
                        if (cmp_cmd_valid && cmp_cmd_ready) begin
                            retire     = 1'b1;
                            state_next = ST_FETCH;
                        end
                    end
                    CLS_BARRIER: state_next = ST_DRAIN_B;
                    default:     state_next = ST_DRAIN_H;
                endcase
            end
            ST_DRAIN_B: begin
                if (&unit_zero) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN_H: begin
                if (&unit_zero) begin
                    retire     = 1'b1;
                    state_next = ST_HALTED;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The instruction register captures FIFO data the cycle after the pop
    assign ir_next    = (state_reg == ST_WAIT) ? isa_fifo_dout : ir_reg;
    assign count_next = clear_run ? '0 : (count_reg + CNT_W'(retire));
    assign err_next   = clear_run ? (|unit_underflow) : (err_reg | (|unit_underflow));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ir_reg    <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ir_reg    <= ir_next;
            count_reg <= count_next;
            err_reg   <= err_next;
        end
    end

    assign dma_cmd_data = ir_reg[PAYLOAD_W-1:0];
    assign cmp_cmd_data = ir_reg[PAYLOAD_W-1:0];
    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_HALTED);
    assign halted       = (state_reg == ST_HALTED);
    assign err          = err_reg;
    assign instr_count  = count_reg;

endmodule
